long_add_carry_resolve: RTL and testbench

- Downstream stage of the segmented long adder. It consumes the registered per-segment results of the segment adders: an SEG+1-bit sum whose top bit is the segment carry-out (generate), and the propagate flag (low SEG sum bits all ones).
- Resolves inter-segment carries with a generate/propagate chain, then increments each segment's low sum by its resolved carry-in.
- Emits the full NSEG*SEG-bit sum plus carry-out through a 2-stage valid/ready pipeline.

---
 rtl/long_add_carry_resolve.sv | 117 +++++++++++
 tb/tb_long_add_carry_resolve.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/long_add_carry_resolve.sv
// Carry-resolve stage of the segmented long adder: turns per-segment generate/propagate
// results into the full sum through a two-register valid/ready pipeline with a global stall.
module long_add_carry_resolve #(
  parameter int SEG  = 18,
  parameter int NSEG = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NSEG*(SEG+1)-1:0]   seg_sum,
  input  logic [NSEG-1:0]           seg_p,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NSEG*SEG-1:0]       sum,
  output logic                      cout
);

  localparam int W = NSEG * SEG;

  logic            adv;
  logic [NSEG-1:0] seg_g;
  logic [W-1:0]    seg_low;
  logic [NSEG:0]   carry;

  logic            valid_a_reg;
  logic [W-1:0]    s_reg;
  logic [NSEG:0]   c_reg;
  logic            out_valid_reg;
  logic [W-1:0]    sum_reg;
  logic [W-1:0]    sum_next;
  logic            cout_reg;

  assign adv      = ~out_valid_reg | out_ready;
  assign in_ready = adv;

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_unpack
      assign seg_g[gi]                = seg_sum[gi*(SEG+1) + SEG];
      assign seg_low[gi*SEG +: SEG]   = seg_sum[gi*(SEG+1) +: SEG];
    end
  endgenerate

  // carry[k] is the carry into segment k; carry[NSEG] is the final carry-out.
  generate
    if (NSEG <= 8) begin : g_ripple
      always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int k = 0; k < NSEG; k++) begin
          carry[k+1] = seg_g[k] | (seg_p[k] & carry[k]);
        end
      end
    end else begin : g_prefix
      localparam int LVL = $clog2(NSEG);
      logic [NSEG-1:0] pg [LVL+1];
      logic [NSEG-1:0] pp [LVL+1];

      // cin is folded into segment 0's generate, so the group generate over [k:0] is carry[k+1].
      always_comb begin
        for (int l = 0; l <= LVL; l++) begin
          pg[l] = '0;
          pp[l] = '0;
        end
        pg[0]    = seg_g;
        pg[0][0] = seg_g[0] | (seg_p[0] & cin);
        pp[0]    = seg_p;
        for (int l = 0; l < LVL; l++) begin
          for (int i = 0; i < NSEG; i++) begin
            if (i >= (1 << l)) begin
              pg[l+1][i] = pg[l][i] | (pp[l][i] & pg[l][i - (1 << l)]);
              pp[l+1][i] = pp[l][i] & pp[l][i - (1 << l)];
            end else begin
              pg[l+1][i] = pg[l][i];
              pp[l+1][i] = pp[l][i];
            end
          end
        end
        carry = {pg[LVL], cin};
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_incr
      assign sum_next[gi*SEG +: SEG] = s_reg[gi*SEG +: SEG] + {{(SEG-1){1'b0}}, c_reg[gi]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_a_reg   <= 1'b0;
      s_reg         <= '0;
      c_reg         <= '0;
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
    end else if (adv) begin
      valid_a_reg <= in_valid;
      if (in_valid) begin
        s_reg <= seg_low;
        c_reg <= carry;
      end
      out_valid_reg <= valid_a_reg;
      if (valid_a_reg) begin
        sum_reg  <= sum_next;
        cout_reg <= c_reg[NSEG];
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

// File: tb/tb_long_add_carry_resolve.sv
// Bench for long_add_carry_resolve: directed vector table, stall/reset sequences and
// a randomized stream checked against plain long-integer addition through a FIFO model.
module tb_long_add_carry_resolve;

  localparam int SEG  = 18;
  localparam int NSEG = 4;
  localparam int W    = NSEG * SEG;
  localparam int SW   = NSEG * (SEG + 1);

  typedef logic [W:0] val_t;

  typedef struct {
    logic [SW-1:0]   ss;
    logic [NSEG-1:0] p;
    logic            ci;
    logic [W:0]      exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   seg_sum;
  logic [NSEG-1:0] seg_p;
  logic            cin;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    sum;
  logic            cout;

  int tests = 0;
  int fails = 0;

  vec_t vecs [8];

  long_add_carry_resolve #(.SEG(SEG), .NSEG(NSEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seg_sum   (seg_sum),
    .seg_p     (seg_p),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input val_t act, input val_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [SEG:0] fld(input logic g, input logic [SEG-1:0] lo);
    return {g, lo};
  endfunction

  // Models the upstream segment adders, and the expected result as one wide addition.
  task automatic make_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           output logic [SW-1:0] ss, output logic [NSEG-1:0] pp,
                           output val_t exp);
    logic [SEG:0] t;
    for (int k = 0; k < NSEG; k++) begin
      t = {1'b0, a[k*SEG +: SEG]} + {1'b0, b[k*SEG +: SEG]};
      ss[k*(SEG+1) +: SEG+1] = t;
      pp[k] = &t[SEG-1:0];
    end
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endtask

  task automatic send_one(input string name, input logic [SW-1:0] ss, input logic [NSEG-1:0] pp,
                          input logic ci, input val_t exp);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    seg_sum   = ss;
    seg_p     = pp;
    cin       = ci;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_early"}, val_t'(out_valid), val_t'(1'b0));
    @(posedge clk); #1;
    check({name, "_valid"}, val_t'(out_valid), val_t'(1'b1));
    check({name, "_data"}, {cout, sum}, exp);
  endtask

  // mode rnd=0: data 1..nbeats with out_ready low in cycles 3-5; rnd=1: random traffic.
  task automatic run_stream(input string name, input int nbeats, input bit rnd, input int max_cyc);
    val_t            q[$];
    val_t            e;
    val_t            cur_exp;
    logic [SW-1:0]   cur_ss;
    logic [NSEG-1:0] cur_p;
    logic            cur_ci;
    logic [95:0]     r;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    int              sent = 0;
    int              got = 0;
    bit              acc = 1'b0;
    bit              need = 1'b1;
    for (int cyc = 0; cyc < max_cyc && got < nbeats; cyc++) begin
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        acc  = 1'b0;
        need = 1'b1;
      end
      if (need) begin
        if (rnd) begin
          r = {$urandom(), $urandom(), $urandom()};
          a = r[W-1:0];
          r = {$urandom(), $urandom(), $urandom()};
          b = ($urandom_range(0, 3) == 0) ? ~a : r[W-1:0];
          cur_ci = 1'($urandom_range(0, 1));
        end else begin
          a = W'(sent + 1);
          b = '0;
          cur_ci = 1'b0;
        end
        make_beat(a, b, cur_ci, cur_ss, cur_p, cur_exp);
        need = 1'b0;
      end
      in_valid  = (sent < nbeats) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(cyc >= 3 && cyc <= 5);
      seg_sum   = cur_ss;
      seg_p     = cur_p;
      cin       = cur_ci;
      @(negedge clk);
      check($sformatf("%s_in_ready_c%0d", name, cyc), val_t'(in_ready),
            val_t'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check($sformatf("%s_spurious_c%0d", name, cyc), val_t'(1'b1), val_t'(1'b0));
        end else begin
          e = q.pop_front();
          check($sformatf("%s_out%0d", name, got), {cout, sum}, e);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(cur_exp);
        acc = 1'b1;
      end
    end
    check({name, "_count"}, val_t'(got), val_t'(nbeats));
    check({name, "_left"}, val_t'(q.size()), val_t'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [SW-1:0]   ss;
    logic [NSEG-1:0] pp;
    val_t            ex;

    vecs[0] = '{{fld(1'b0, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0)},
                4'b0000, 1'b1, {1'b0, 18'h0, 18'h0, 18'h0, 18'h1}};
    vecs[1] = '{{4{fld(1'b0, 18'h3FFFF)}}, 4'b1111, 1'b1, {1'b1, 72'h0}};
    vecs[2] = '{{4{fld(1'b0, 18'h3FFFF)}}, 4'b1111, 1'b0, {1'b0, {72{1'b1}}}};
    vecs[3] = '{{fld(1'b0, 18'h0), fld(1'b0, 18'h10), fld(1'b0, 18'h3FFFF), fld(1'b1, 18'h5)},
                4'b0010, 1'b0, {1'b0, 18'h0, 18'h11, 18'h0, 18'h5}};
    vecs[4] = '{{fld(1'b1, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0)},
                4'b0000, 1'b0, {1'b1, 72'h0}};
    vecs[5] = '{{fld(1'b0, 18'h3FFFF), fld(1'b1, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0)},
                4'b1000, 1'b0, {1'b1, 72'h0}};
    // g and p both set on segment 0: generate wins, carry still reaches segment 1.
    vecs[6] = '{{fld(1'b0, 18'h0), fld(1'b0, 18'h0), fld(1'b0, 18'h0), fld(1'b1, 18'h3FFFF)},
                4'b0001, 1'b1, {1'b0, 18'h0, 18'h0, 18'h1, 18'h0}};
    vecs[7] = '{{fld(1'b0, 18'h7), fld(1'b0, 18'h3FFFF), fld(1'b0, 18'h3FFFF), fld(1'b1, 18'h0)},
                4'b0110, 1'b0, {1'b0, 18'h8, 18'h0, 18'h0, 18'h0}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    seg_sum   = '0;
    seg_p     = '0;
    cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", val_t'(out_valid), val_t'(1'b0));
    check("reset_sum", val_t'(sum), val_t'(0));
    check("reset_cout", val_t'(cout), val_t'(1'b0));
    check("reset_in_ready", val_t'(in_ready), val_t'(1'b1));

    for (int i = 0; i < 8; i++) begin
      send_one($sformatf("vec%0d", i), vecs[i].ss, vecs[i].p, vecs[i].ci, vecs[i].exp);
    end

    run_stream("stall", 5, 1'b0, 10);

    // Reset while one beat sits stalled at the output and another in stage A.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    make_beat(72'h111, 72'h0, 1'b0, ss, pp, ex);
    seg_sum = ss; seg_p = pp; cin = 1'b0;
    @(posedge clk); #1;
    make_beat(72'h222, 72'h0, 1'b0, ss, pp, ex);
    seg_sum = ss; seg_p = pp;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_stalled", val_t'(out_valid), val_t'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_out_valid", val_t'(out_valid), val_t'(1'b0));
    check("rst_mid_sum", val_t'(sum), val_t'(0));
    check("rst_mid_cout", val_t'(cout), val_t'(1'b0));
    check("rst_mid_in_ready", val_t'(in_ready), val_t'(1'b1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_no_ghost%0d", i), val_t'(out_valid), val_t'(1'b0));
    end
    make_beat(72'h123456789ABCDEF, 72'hFFF, 1'b1, ss, pp, ex);
    send_one("post_rst", ss, pp, 1'b1, ex);

    run_stream("rand", 150, 1'b1, 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
